// File: rtl/sccb_target_if.sv
// rtl/sccb_target_if.sv - parallel register port between the SCCB target and its register file
interface sccb_target_if;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic [7:0] wr_cnt;
  logic       busy;

  modport master (
    output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, wr_cnt, busy,
    input  reg_rd_data
  );

  modport slave (
    input  reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, wr_cnt, busy,
    output reg_rd_data
  );
endinterface

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB responder: decodes 3-phase writes and 2-phase write/read
// cycles addressed to DEV_ID and exposes them on a parallel register port.
module sccb_target #(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned TIMEOUT_NUM = 20000
) (
  input  logic          clk_10MHz,
  input  logic          rst,
  input  logic          sioc,
  inout  wire           siod,
  sccb_target_if.master reg_port
);
  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;
  localparam int TO_W = $clog2(TIMEOUT_NUM);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_NUM - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ACK_ID, S_ADDR, S_ACK_ADDR,
    S_WDATA, S_ACK_WDATA, S_RDATA, S_RD_NACK, S_IGNORE
  } state_e;

  state_e          state_q;
  logic            sioc_s1_q, sioc_s2_q, sioc_prev_q;
  logic            siod_s1_q, siod_s2_q, siod_prev_q;
  logic [7:0]      sh_q;
  logic [6:0]      tx_q;
  logic [3:0]      bit_cnt_q;
  logic            rd_mode_q;
  logic            sda_low_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [7:0]      reg_addr_q, reg_wr_data_q, wr_cnt_q;
  logic            reg_wr_en_q, reg_rd_en_q;

  logic sioc_rise, sioc_fall, start_ev, stop_ev, byte_done;

  assign siod      = sda_low_q ? 1'b0 : 1'bz;
  assign sioc_rise = sioc_s2_q & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s2_q & sioc_prev_q;
  assign start_ev  = sioc_s2_q & sioc_prev_q & siod_prev_q & ~siod_s2_q;
  assign stop_ev   = sioc_s2_q & sioc_prev_q & ~siod_prev_q & siod_s2_q;
  assign byte_done = (bit_cnt_q == 4'd8);

  assign reg_port.reg_addr    = reg_addr_q;
  assign reg_port.reg_wr_en   = reg_wr_en_q;
  assign reg_port.reg_wr_data = reg_wr_data_q;
  assign reg_port.reg_rd_en   = reg_rd_en_q;
  assign reg_port.wr_cnt      = wr_cnt_q;
  assign reg_port.busy        = (state_q != S_IDLE);

  always_ff @(posedge clk_10MHz) begin
    if (rst) begin
      state_q       <= S_IDLE;
      // Synchronizers reset to the idle-bus level so no phantom START/STOP appears.
      sioc_s1_q     <= 1'b1;
      sioc_s2_q     <= 1'b1;
      sioc_prev_q   <= 1'b1;
      siod_s1_q     <= 1'b1;
      siod_s2_q     <= 1'b1;
      siod_prev_q   <= 1'b1;
      sh_q          <= 8'h00;
      tx_q          <= 7'h00;
      bit_cnt_q     <= 4'd0;
      rd_mode_q     <= 1'b0;
      sda_low_q     <= 1'b0;
      to_cnt_q      <= '0;
      reg_addr_q    <= 8'h00;
      reg_wr_data_q <= 8'h00;
      wr_cnt_q      <= 8'h00;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
    end else begin
      sioc_s1_q   <= sioc;
      sioc_s2_q   <= sioc_s1_q;
      sioc_prev_q <= sioc_s2_q;
      siod_s1_q   <= siod;
      siod_s2_q   <= siod_s1_q;
      siod_prev_q <= siod_s2_q;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;

      if (sioc_rise || sioc_fall || state_q == S_IDLE) to_cnt_q <= '0;
      else                                              to_cnt_q <= to_cnt_q + 1'b1;

      if (start_ev) begin
        state_q   <= S_ID;
        bit_cnt_q <= 4'd0;
        sda_low_q <= 1'b0;
      end else if (stop_ev) begin
        state_q   <= S_IDLE;
        sda_low_q <= 1'b0;
      end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
        state_q   <= S_IDLE;
        sda_low_q <= 1'b0;
      end else if (sioc_rise) begin
        if ((state_q == S_ID || state_q == S_ADDR || state_q == S_WDATA ||
             state_q == S_RDATA) && !byte_done) begin
          sh_q      <= {sh_q[6:0], siod_s2_q};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (sioc_fall) begin
        case (state_q)
          S_ID: if (byte_done) begin
            if (sh_q == DEV_ID) begin
              state_q   <= S_ACK_ID;
              rd_mode_q <= 1'b0;
              sda_low_q <= 1'b1;
            end else if (sh_q == RD_ID) begin
              state_q     <= S_ACK_ID;
              rd_mode_q   <= 1'b1;
              sda_low_q   <= 1'b1;
              reg_rd_en_q <= 1'b1;
            end else begin
              state_q <= S_IGNORE;
            end
          end
          S_ACK_ID: begin
            bit_cnt_q <= 4'd0;
            if (rd_mode_q) begin
              // Read data is captured here, long after reg_rd_en, and its MSB driven at once.
              state_q   <= S_RDATA;
              tx_q      <= reg_port.reg_rd_data[6:0];
              sda_low_q <= ~reg_port.reg_rd_data[7];
            end else begin
              state_q   <= S_ADDR;
              sda_low_q <= 1'b0;
            end
          end
          S_ADDR: if (byte_done) begin
            state_q    <= S_ACK_ADDR;
            reg_addr_q <= sh_q;
            sda_low_q  <= 1'b1;
          end
          S_ACK_ADDR: begin
            state_q   <= S_WDATA;
            bit_cnt_q <= 4'd0;
            sda_low_q <= 1'b0;
          end
          S_WDATA: if (byte_done) begin
            state_q       <= S_ACK_WDATA;
            reg_wr_data_q <= sh_q;
            reg_wr_en_q   <= 1'b1;
            sda_low_q     <= 1'b1;
            if (wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
          end
          S_ACK_WDATA: begin
            state_q   <= S_IGNORE;
            sda_low_q <= 1'b0;
          end
          S_RDATA: begin
            if (byte_done) begin
              state_q   <= S_RD_NACK;
              sda_low_q <= 1'b0;
            end else begin
              sda_low_q <= ~tx_q[6];
              tx_q      <= {tx_q[5:0], 1'b0};
            end
          end
          S_RD_NACK: state_q <= S_IGNORE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed and randomized SCCB master driving sccb_target,
// checked against a transaction-level model of acks, strobes and counters.
module tb_sccb_target;
  localparam logic [7:0] DEV_ID      = 8'h42;
  localparam logic [7:0] RD_ID       = 8'h43;
  localparam int         TIMEOUT_NUM = 20000;

  logic clk_10MHz = 1'b0;
  logic rst;
  logic sioc;
  logic m_low;
  wire  siod;

  sccb_target_if rp();

  sccb_target #(.DEV_ID(DEV_ID), .TIMEOUT_NUM(TIMEOUT_NUM)) dut (
    .clk_10MHz (clk_10MHz),
    .rst       (rst),
    .sioc      (sioc),
    .siod      (siod),
    .reg_port  (rp)
  );

  assign siod = m_low ? 1'b0 : 1'bz;
  pullup (siod);

  always #50 clk_10MHz = ~clk_10MHz;

  int checks   = 0;
  int failures = 0;
  int rd_pulses = 0;
  logic [15:0] seen_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  exp_addr, exp_wdata;
  int          exp_cnt;

  always @(negedge clk_10MHz) begin
    if (rp.reg_wr_en === 1'b1) seen_q.push_back({rp.reg_addr, rp.reg_wr_data});
    if (rp.reg_rd_en === 1'b1) rd_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk_10MHz);
  endtask

  // Acknowledge rule per byte position for a write-addressed transaction.
  function automatic bit exp_ack(input logic [7:0] id, input int idx);
    if (idx == 0) return (id == DEV_ID) || (id == RD_ID);
    return (id == DEV_ID) && (idx <= 2);
  endfunction

  task automatic model_reset();
    exp_addr = 8'h00; exp_wdata = 8'h00; exp_cnt = 0;
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic model_write(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d, input int n);
    if (id != DEV_ID) return;
    if (n >= 2) exp_addr = a;
    if (n >= 3) begin
      exp_wdata = d;
      exp_q.push_back({a, d});
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_addr"},    rp.reg_addr,    exp_addr);
    chk({tag, "_wdata"},   rp.reg_wr_data, exp_wdata);
    chk({tag, "_wrcnt"},   rp.wr_cnt,      exp_cnt);
    chk({tag, "_nstrobe"}, seen_q.size(),  exp_q.size());
    while (seen_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_strobe"}, seen_q.pop_front(), exp_q.pop_front());
    seen_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; sioc = 1'b1; m_low = 1'b0;
    clk_wait(n);
    rst = 1'b0;
    clk_wait(2);
    model_reset();
  endtask

  task automatic do_start();
    clk_wait(2);
    if (sioc === 1'b0) begin
      m_low = 1'b0; clk_wait(2); sioc = 1'b1; clk_wait(3);
    end
    m_low = 1'b1; clk_wait(3); sioc = 1'b0;
  endtask

  task automatic do_stop();
    clk_wait(2); m_low = 1'b1; clk_wait(2); sioc = 1'b1; clk_wait(3); m_low = 1'b0; clk_wait(6);
  endtask

  task automatic send_bit(input logic b, output logic s);
    clk_wait(2); m_low = ~b; clk_wait(2); sioc = 1'b1; clk_wait(3); s = siod; sioc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] rx, output bit ack_low);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], s);
      rx[i] = s;
    end
    send_bit(1'b1, s);
    ack_low = (s === 1'b0);
  endtask

  task automatic wr_txn(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                        input int n, input bit stop);
    logic [7:0] rx, v;
    bit ackl;
    do_start();
    for (int k = 0; k < n; k++) begin
      v = (k == 0) ? id : (k == 1) ? a : (k == 2) ? d : ~d;
      send_byte(v, rx, ackl);
      chk($sformatf("ack_id%02h_b%0d", id, k), ackl, exp_ack(id, k));
    end
    if (stop) do_stop();
    model_write(id, a, d, n);
  endtask

  task automatic rd_txn(input logic [7:0] data, input string tag);
    logic [7:0] rx;
    bit ackl;
    int p0;
    p0 = rd_pulses;
    rp.reg_rd_data = data;
    do_start();
    send_byte(RD_ID, rx, ackl);
    chk({tag, "_rdid_ack"}, ackl, 1'b1);
    send_byte(8'hFF, rx, ackl);
    chk({tag, "_rdata"}, rx, data);
    chk({tag, "_rd_9th_released"}, ackl, 1'b0);
    do_stop();
    chk({tag, "_rd_pulses"}, rd_pulses - p0, 1);
  endtask

  initial begin
    logic [7:0] rx, id, a, d;
    logic s;
    bit ackl;
    int r, n;

    rp.reg_rd_data = 8'h00;
    do_reset(3);
    chk("rst_busy",    rp.busy,        1'b0);
    chk("rst_addr",    rp.reg_addr,    8'h00);
    chk("rst_wdata",   rp.reg_wr_data, 8'h00);
    chk("rst_wr_en",   rp.reg_wr_en,   1'b0);
    chk("rst_rd_en",   rp.reg_rd_en,   1'b0);
    chk("rst_wr_cnt",  rp.wr_cnt,      8'h00);
    chk("rst_siod",    siod,           1'b1);

    wr_txn(DEV_ID, 8'h12, 8'h80, 3, 1'b1);
    chk("w3_busy", rp.busy, 1'b0);
    chk_model("w3");

    wr_txn(8'h60, 8'h12, 8'h34, 2, 1'b0);
    chk("badid_busy_before_stop", rp.busy, 1'b1);
    do_stop();
    chk("badid_busy_after_stop", rp.busy, 1'b0);
    chk_model("badid");

    wr_txn(DEV_ID, 8'h0A, 8'h00, 2, 1'b1);
    rd_txn(8'h76, "rd76");
    chk_model("rd76");

    repeat (8) begin
      r = $urandom_range(0, 4);
      if (r == 0) begin
        rd_txn(8'($urandom), "rnd");
      end else begin
        id = (r == 1) ? 8'($urandom) : DEV_ID;
        if (id == RD_ID) id = 8'h44;
        n = $urandom_range(1, 4);
        wr_txn(id, 8'($urandom), 8'($urandom), n, 1'b1);
      end
      chk("rnd_busy", rp.busy, 1'b0);
      chk_model("rnd");
    end

    // Reset while the target is pulling siod low for an ID ack.
    do_start();
    for (int i = 7; i >= 0; i--) send_bit(DEV_ID[i], s);
    clk_wait(4);
    chk("ackid_driving", siod, 1'b0);
    rst = 1'b1; sioc = 1'b1; m_low = 1'b0;
    clk_wait(1);
    chk("rst_in_ack_siod", siod, 1'b1);
    chk("rst_in_ack_busy", rp.busy, 1'b0);
    rst = 1'b0;
    clk_wait(4);
    model_reset();

    // Reset at bit 4 of the address byte.
    do_start();
    send_byte(DEV_ID, rx, ackl);
    chk("rstaddr_id_ack", ackl, 1'b1);
    for (int i = 7; i >= 4; i--) send_bit(8'hC5 >> i, s);
    chk("rstaddr_busy_pre", rp.busy, 1'b1);
    rst = 1'b1; sioc = 1'b1; m_low = 1'b0;
    clk_wait(1);
    chk("rstaddr_siod", siod, 1'b1);
    chk("rstaddr_busy", rp.busy, 1'b0);
    rst = 1'b0;
    clk_wait(4);
    model_reset();
    chk_model("rstaddr");
    wr_txn(DEV_ID, 8'h05, 8'h33, 3, 1'b1);
    chk_model("post_rst");

    do_reset(2);
    for (int i = 0; i < 179; i++) begin
      a = 8'(i);
      wr_txn(DEV_ID, a, ~a, 3, 1'b0);
    end
    do_stop();
    chk("b2b_wr_cnt", rp.wr_cnt, 179);
    chk_model("b2b");

    // Stall sioc three bits into the data byte.
    do_start();
    send_byte(DEV_ID, rx, ackl);
    chk("to_id_ack", ackl, 1'b1);
    send_byte(8'h21, rx, ackl);
    chk("to_addr_ack", ackl, 1'b1);
    exp_addr = 8'h21;
    for (int i = 7; i >= 5; i--) send_bit(8'hA5 >> i, s);
    clk_wait(TIMEOUT_NUM - 10);
    chk("to_busy_before", rp.busy, 1'b1);
    clk_wait(20);
    chk("to_busy_after", rp.busy, 1'b0);
    chk("to_siod", siod, 1'b1);
    sioc = 1'b1; m_low = 1'b0;
    clk_wait(6);
    chk_model("timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
